// File: rtl/regfile_sb.sv
// 32x32 register file with a per-GPR pending-write scoreboard.
// Reads and busy are combinational; writes, counters and flags update 1 cycle later; there is no backpressure.
module regfile_sb (
   input  logic        clk,
   input  logic        rst,
   input  logic [37:0] wb_to_rf_bus,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        issue_we,
   input  logic [4:0]  issue_waddr,
   input  logic        flush,
   output logic        busy1,
   output logic        busy2,
   output logic        sb_overflow,
   output logic        sb_underflow
);

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } wb_t;

   wb_t         wb;
   logic        wr_vld;
   logic        inc_vld;
   logic        inc_hit;
   logic        dec_hit;
   logic [31:0] gpr_q [32];
   logic [31:0] gpr_d [32];
   logic [1:0]  cnt_q [32];
   logic [1:0]  cnt_d [32];
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;

   assign wb      = wb_t'(wb_to_rf_bus);
   assign wr_vld  = wb.we && (wb.waddr != 5'd0);
   assign inc_vld = issue_we && (issue_waddr != 5'd0);

   always_comb begin
      gpr_d   = gpr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      inc_hit = 1'b0;
      dec_hit = 1'b0;
      if (wr_vld) begin
         gpr_d[wb.waddr] = wb.wdata;
      end
      // Entry 0 is never touched, so it holds its reset value of zero.
      for (int i = 1; i < 32; i++) begin
         inc_hit = inc_vld && (issue_waddr == 5'(i));
         dec_hit = wr_vld && (wb.waddr == 5'(i));
         if (flush) begin
            cnt_d[i] = 2'd0;
         end else if (inc_hit && !dec_hit) begin
            if (cnt_q[i] == 2'd3) ovf_d = 1'b1;
            else                  cnt_d[i] = cnt_q[i] + 2'd1;
         end else if (dec_hit && !inc_hit) begin
            if (cnt_q[i] == 2'd0) unf_d = 1'b1;
            else                  cnt_d[i] = cnt_q[i] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            gpr_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         gpr_q <= gpr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   logic byp1, byp2, last1, last2;

   assign byp1 = wr_vld && (wb.waddr == raddr1);
   assign byp2 = wr_vld && (wb.waddr == raddr2);
   // A lone retirement of the last pending write releases busy in the same cycle.
   assign last1 = (cnt_q[raddr1] == 2'd1) && byp1 && !(inc_vld && (issue_waddr == raddr1));
   assign last2 = (cnt_q[raddr2] == 2'd1) && byp2 && !(inc_vld && (issue_waddr == raddr2));

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      busy1  = 1'b0;
      busy2  = 1'b0;
      if (raddr1 != 5'd0) begin
         rdata1 = byp1 ? wb.wdata : gpr_q[raddr1];
         busy1  = (cnt_q[raddr1] != 2'd0) && !last1;
      end
      if (raddr2 != 5'd0) begin
         rdata2 = byp2 ? wb.wdata : gpr_q[raddr2];
         busy2  = (cnt_q[raddr2] != 2'd0) && !last2;
      end
   end

   assign sb_overflow  = ovf_q;
   assign sb_underflow = unf_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: expectations are queued per vector and checked at negedge.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [4:0]  raddr1, raddr2;
   logic        issue_we;
   logic [4:0]  issue_waddr;
   logic        flush;
   logic [31:0] rdata1, rdata2;
   logic        busy1, busy2, sb_overflow, sb_underflow;

   int n_cmp = 0;
   int n_bad = 0;
   int vec_id = 0;

   typedef struct {
      int          id;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        b1;
      logic        b2;
      logic        ov;
      logic        un;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk          (clk),
      .rst          (rst),
      .wb_to_rf_bus ({we, wa, wd}),
      .raddr1       (raddr1),
      .raddr2       (raddr2),
      .rdata1       (rdata1),
      .rdata2       (rdata2),
      .issue_we     (issue_we),
      .issue_waddr  (issue_waddr),
      .flush        (flush),
      .busy1        (busy1),
      .busy2        (busy2),
      .sb_overflow  (sb_overflow),
      .sb_underflow (sb_underflow)
   );

   task automatic cmp(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL v%0d %s: got %h expected %h", id, nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         cmp(e.id, "rdata1",       rdata1,              e.rd1);
         cmp(e.id, "rdata2",       rdata2,              e.rd2);
         cmp(e.id, "busy1",        {31'd0, busy1},        {31'd0, e.b1});
         cmp(e.id, "busy2",        {31'd0, busy2},        {31'd0, e.b2});
         cmp(e.id, "sb_overflow",  {31'd0, sb_overflow},  {31'd0, e.ov});
         cmp(e.id, "sb_underflow", {31'd0, sb_underflow}, {31'd0, e.un});
      end
   end

   // Drive one cycle of inputs; when chk is set, queue the outputs expected in that cycle.
   task automatic step(input logic rs, input logic fl,
                       input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic iw, input logic [4:0] ia,
                       input logic chk,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input logic eb1, input logic eb2, input logic eov, input logic eun);
      exp_t e;
      rst = rs; flush = fl; we = w; wa = a; wd = d;
      raddr1 = r1; raddr2 = r2; issue_we = iw; issue_waddr = ia;
      if (chk) begin
         e.id = vec_id; e.rd1 = e1; e.rd2 = e2;
         e.b1 = eb1; e.b2 = eb2; e.ov = eov; e.un = eun;
         sb_q.push_back(e);
      end
      vec_id++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; we = 1'b0; wa = '0; wd = '0;
      raddr1 = '0; raddr2 = '0; issue_we = 1'b0; issue_waddr = '0;
      @(posedge clk);
      #1;
      //    rs fl we wa     wd            r1     r2     iw ia    chk rd1           rd2           b1 b2 ov un
      step(1, 0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  0, 5'd0,  0, 32'h0,        32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd5,  5'd31, 0, 5'd0,  1, 32'h0,        32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd5,  5'd0,  1, 5'd5,  1, 32'h0,        32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd5,  5'd0,  1, 5'd7,  1, 32'h0,        32'h0,        1, 0, 0, 0);
      step(0, 0, 1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd7,  0, 5'd0,  1, 32'hDEADBEEF, 32'h0,        0, 1, 0, 0);
      step(0, 0, 1, 5'd0,  32'h00001234, 5'd5,  5'd0,  0, 5'd0,  1, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0);
      step(0, 0, 1, 5'd7,  32'hA5A5A5A5, 5'd0,  5'd7,  0, 5'd0,  1, 32'h0,        32'hA5A5A5A5, 0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd7,  5'd5,  0, 5'd0,  1, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd3,  5'd0,  1, 5'd3,  1, 32'h0,        32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd3,  5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        1, 0, 0, 0);
      step(0, 0, 1, 5'd3,  32'h00000033, 5'd3,  5'd0,  0, 5'd0,  1, 32'h00000033, 32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd3,  5'd0,  0, 5'd0,  1, 32'h00000033, 32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd0,  5'd4,  1, 5'd4,  1, 32'h0,        32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd0,  5'd4,  1, 5'd4,  1, 32'h0,        32'h0,        0, 1, 0, 0);
      step(0, 0, 1, 5'd4,  32'h00000044, 5'd0,  5'd4,  1, 5'd4,  1, 32'h0,        32'h00000044, 0, 1, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd0,  5'd4,  0, 5'd0,  1, 32'h0,        32'h00000044, 0, 1, 0, 0);
      step(0, 0, 1, 5'd4,  32'h00000045, 5'd0,  5'd4,  0, 5'd0,  1, 32'h0,        32'h00000045, 0, 1, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd0,  5'd4,  1, 5'd4,  1, 32'h0,        32'h00000045, 0, 1, 0, 0);
      step(0, 1, 0, 5'd0,  32'h0,        5'd0,  5'd4,  1, 5'd4,  1, 32'h0,        32'h00000045, 0, 1, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd0,  5'd4,  0, 5'd0,  1, 32'h0,        32'h00000045, 0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd6,  5'd0,  1, 5'd6,  1, 32'h0,        32'h0,        0, 0, 0, 0);
      step(0, 0, 1, 5'd6,  32'h00000066, 5'd6,  5'd0,  1, 5'd6,  1, 32'h00000066, 32'h0,        1, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd6,  5'd0,  0, 5'd0,  1, 32'h00000066, 32'h0,        1, 0, 0, 0);
      step(0, 1, 0, 5'd0,  32'h0,        5'd6,  5'd0,  0, 5'd0,  1, 32'h00000066, 32'h0,        1, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd6,  5'd0,  0, 5'd0,  1, 32'h00000066, 32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  1, 5'd9,  1, 32'h0,        32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  1, 5'd9,  1, 32'h0,        32'h0,        1, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  1, 5'd9,  1, 32'h0,        32'h0,        1, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  1, 5'd9,  1, 32'h0,        32'h0,        1, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        1, 0, 1, 0);
      step(0, 0, 1, 5'd12, 32'h00C0FFEE, 5'd0,  5'd12, 0, 5'd0,  1, 32'h0,        32'h00C0FFEE, 0, 0, 1, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd12, 0, 5'd0,  1, 32'h0,        32'h00C0FFEE, 1, 0, 1, 1);
      step(0, 1, 0, 5'd0,  32'h0,        5'd9,  5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        1, 0, 1, 1);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  0, 5'd0,  1, 32'h0,        32'h0,        0, 0, 1, 1);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  1, 5'd9,  1, 32'h0,        32'h0,        0, 0, 1, 1);
      step(0, 0, 0, 5'd0,  32'h0,        5'd9,  5'd0,  1, 5'd9,  1, 32'h0,        32'h0,        1, 0, 1, 1);
      step(1, 0, 0, 5'd0,  32'h0,        5'd5,  5'd9,  0, 5'd0,  1, 32'hDEADBEEF, 32'h0,        0, 1, 1, 1);
      step(0, 0, 0, 5'd0,  32'h0,        5'd5,  5'd9,  0, 5'd0,  1, 32'h0,        32'h0,        0, 0, 0, 0);
      step(0, 1, 1, 5'd12, 32'h00000012, 5'd0,  5'd12, 1, 5'd13, 1, 32'h0,        32'h00000012, 0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd13, 5'd12, 0, 5'd0,  1, 32'h0,        32'h00000012, 0, 0, 0, 0);
      step(1, 0, 1, 5'd20, 32'h00000020, 5'd20, 5'd0,  1, 5'd20, 1, 32'h00000020, 32'h0,        0, 0, 0, 0);
      step(0, 0, 0, 5'd0,  32'h0,        5'd20, 5'd12, 0, 5'd0,  1, 32'h0,        32'h0,        0, 0, 0, 0);
      repeat (3) @(posedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expectations expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The module SHALL have these ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- wb_to_rf_bus  input  `WB_TO_RF_WD (38)  write port driven by the writeback stage, packed {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- raddr1  input  5  read port 1 address.
- raddr2  input  5  read port 2 address.
- rdata1  output  32  read port 1 data.
- rdata2  output  32  read port 2 data.
- issue_we  input  1  decode issued an instruction that will write a GPR.
- issue_waddr  input  5  destination GPR of the issued instruction.
- flush  input  1  discard all outstanding pending-write tracking.
- busy1  output  1  GPR at raddr1 has an outstanding write not yet available.
- busy2  output  1  GPR at raddr2 has an outstanding write not yet available.
- sb_overflow  output  1  sticky error flag: pending count saturation.
- sb_underflow  output  1  sticky error flag: write retired with no pending count.

REQ-002 Reset is synchronous and active-high on rst, sampled at posedge clk; there is a single clock, clk.

Function
REQ-003 Storage SHALL be 32 x 32-bit GPRs; GPR 0 SHALL read as 0 and SHALL never be written.
REQ-004 A write SHALL commit at posedge clk when rf_we=1 and rf_waddr!=0; write latency is 1 cycle.
REQ-005 rdata1/rdata2 SHALL be combinational: 0 when the address is 0; rf_wdata when rf_we=1 and rf_waddr equals the nonzero read address (same-cycle write-through bypass); otherwise the stored value.
REQ-006 Each GPR 1..31 SHALL have a 2-bit pending counter (0..3) counting issued-but-not-retired writes.
REQ-007 An increment event SHALL be issue_we=1 and issue_waddr!=0; a decrement event SHALL be rf_we=1 and rf_waddr!=0.
REQ-008 Increment and decrement to the same GPR in the same cycle SHALL leave that counter unchanged, with no flag update.
REQ-009 An increment on a counter already at 3 SHALL leave it at 3 and set sb_overflow.
REQ-010 A decrement on a counter at 0 SHALL leave it at 0 and set sb_underflow; the GPR write still commits.
REQ-011 Events to GPR 0 SHALL be ignored entirely, with no counter or flag change.
REQ-012 busyN SHALL be 0 when raddrN=0; otherwise busyN SHALL be 1 iff count[raddrN]!=0, except that it SHALL be 0 when count[raddrN]=1, a decrement to raddrN occurs this cycle, and no increment to raddrN occurs this cycle.
REQ-013 flush=1 SHALL clear all counters to 0 at the next posedge; flush SHALL override simultaneous increment and decrement events.
REQ-014 During flush the GPR write of REQ-004 SHALL still commit, and no flag SHALL be set.
REQ-015 sb_overflow and sb_underflow SHALL be sticky until rst; flush SHALL NOT clear them.
REQ-016 Counter, flag and GPR updates SHALL all be registered; no output other than rdata/busy SHALL have a combinational path from inputs.

Reset
REQ-017 While rst=1 at posedge, all GPRs, all counters, sb_overflow and sb_underflow SHALL become 0; rst SHALL override flush, writes and issues in the same cycle.
REQ-018 After reset: rdata1=rdata2=0, busy1=busy2=0, sb_overflow=sb_underflow=0.
REQ-019 Reset asserted mid-operation, with counters nonzero, SHALL discard all pending state in one cycle.

Verification
REQ-020 Write GPR 5 = 0xDEADBEEF, next cycle raddr1=5 -> rdata1=0xDEADBEEF; write GPR 0 = 0x1234 -> rdata(0)=0.
REQ-021 Same cycle: rf_we=1, rf_waddr=7, wdata=0xA5A5A5A5, raddr2=7 -> rdata2=0xA5A5A5A5 combinationally.
REQ-022 Issue to GPR 3, next cycle raddr1=3 -> busy1=1; WB writes GPR 3 while count=1 -> busy1=0 that cycle, count=0 after.
REQ-023 Four issues to GPR 9 with no retire -> count stays 3, sb_overflow=1; retire to GPR 12 at count 0 -> sb_underflow=1 and GPR 12 updated.
REQ-024 Issue and retire to GPR 4 in the same cycle, count=2 -> count remains 2, busy=1; flush with issue to GPR 4 -> all counts 0, busy=0, flags unchanged.
REQ-025 Assert rst with counters nonzero and flags set -> next cycle all counts, flags and GPRs are 0.
